delay_timer: RTL and testbench
==============================

Name: delay_timer

Overview:
- Programmable delay timer serving the processor control FSM.
- Consumes the FSM's start_delay_counter request and produces the delay_done status that the FSM polls in its PAUSE_DELAY and MOVR/MOVRHS_DELAY states.
- Delay length comes from a register-file value, in units of a prescaled tick. It sets the stepper step rate and the PAUSE duration.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- TICK_HZ, 1000, delay unit rate in Hz. PRESCALE = CLK_HZ/TICK_HZ; PRESCALE must be >= 1 (elaboration error otherwise).
- DELAY_W, 8, width of the delay_value operand.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start_delay_counter  in  1  level request from control FSM: run a delay.
- delay_value  in  DELAY_W  delay length in ticks minus one; sampled only on arming.
- delay_done  out  1  single-cycle pulse at end of delay.
- delay_busy  out  1  high while in LOAD or COUNT.
- tick  out  1  prescaler tick strobe, for debug/LED heartbeat.

Behaviour:
- Clocking: one clock (clk). Reset is synchronous and active-low on reset_n. All state changes on rising clk; no combinational path from inputs to outputs.
- Reset (reset_n=0 at an edge):
  - state=IDLE, count=0, pre=0.
  - delay_done=0, delay_busy=0, tick=0.
  - Reset mid-COUNT aborts the delay with no done pulse.
- States: IDLE, LOAD, COUNT, DONE.
- IDLE:
  - start_delay_counter=1 -> LOAD. Otherwise stay.
  - start is level-sensitive: if it stays high after DONE, a new delay re-arms automatically. The FSM relies on this, because it holds start high across MOVR iterations.
- LOAD (1 cycle):
  - count <= delay_value; pre <= PRESCALE-1; -> COUNT. delay_busy=1.
  - delay_value is captured here only; later changes are ignored.
- COUNT:
  - Each cycle pre decrements.
  - When pre==0: tick=1 that cycle.
    - If count==0 -> DONE.
    - Else count <= count-1 and pre <= PRESCALE-1.
  - COUNT lasts exactly (delay_value+1)*PRESCALE cycles.
  - Dropping start during COUNT does not abort; only reset aborts.
- DONE (1 cycle): delay_done=1, delay_busy=0; -> IDLE.
- Latency: start sampled high in IDLE at edge k gives LOAD at k+1, COUNT from k+2, and delay_done high in cycle k+2+(delay_value+1)*PRESCALE.
- Back-to-back period with start held high: (delay_value+1)*PRESCALE + 3 cycles.
- Boundaries:
  - delay_value=0 gives one tick (minimum, never zero-length).
  - delay_value=all-ones gives 2^DELAY_W ticks; no wrap.
  - PRESCALE=1: pre is always 0, so every COUNT cycle is a tick.
- tick is 0 outside COUNT. Counter widths: count is DELAY_W bits; pre is clog2(PRESCALE) bits, with a minimum of 1.
- delay_done is registered and high for exactly one cycle per delay. The FSM samples it while in its *_DELAY state, which covers the pulse.

Decomposition:
- Shared header (delay_timer_defs.vh): 2-bit state encodings DT_IDLE=0, DT_LOAD=1, DT_COUNT=2, DT_DONE=3; default CLK_HZ/TICK_HZ localparams.
- One sub-module: tick_prescaler.
  - Contents: reloadable down-counter with reload input and tick strobe output, parameter PRESCALE.
  - delay_timer instantiates it and drives reload from LOAD and from non-terminal ticks.

Test Plan (CLK_HZ=10, TICK_HZ=1, PRESCALE=10 unless noted):
- Basic delay: reset, then start=1 for 1 cycle at edge k with delay_value=2 -> delay_busy high k+1..k+31, delay_done pulse only at cycle k+32, tick pulses at k+11, k+21, k+31.
- Minimum delay: delay_value=0 -> exactly one tick, done at k+12; delay_value changed to 5 during COUNT -> no effect.
- Held start: start held 1, delay_value=1 -> done pulses every 23 cycles, each 1 cycle wide, for 4 iterations.
- Reset mid-operation: reset_n=0 for 1 cycle at COUNT cycle 7 -> delay_busy=0 next cycle, no delay_done, fresh delay starts cleanly afterwards.
- PRESCALE=1 (TICK_HZ=CLK_HZ), delay_value=255 -> done at k+258; tick high every COUNT cycle; count width does not wrap.
- Start low throughout after reset -> outputs stay 0 for 100 cycles.

Source files
------------

// File: rtl/delay_timer_pkg.sv
// ============================================================================
// Module      : delay_timer_pkg
// Description : State encodings, default rates and width helper for delay_timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package delay_timer_pkg;

    localparam logic [1:0] c_DT_IDLE  = 2'd0;
    localparam logic [1:0] c_DT_LOAD  = 2'd1;
    localparam logic [1:0] c_DT_COUNT = 2'd2;
    localparam logic [1:0] c_DT_DONE  = 2'd3;

    localparam int c_CLK_HZ_DEFAULT  = 50_000_000;
    localparam int c_TICK_HZ_DEFAULT = 1000;

    // A prescale of 1 still needs a 1-bit register that simply stays at 0.
    function automatic int pre_width(input int prescale);
        return (prescale <= 1) ? 1 : $clog2(prescale);
    endfunction

endpackage

`default_nettype wire

// File: rtl/delay_timer_tick_prescaler.sv
// ============================================================================
// Module      : tick_prescaler
// Description : Reloadable down-counter producing a tick when it reaches zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_prescaler
    import delay_timer_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic reload,
    output logic tick
);

    localparam int PRE_W = pre_width(PRESCALE);
    localparam logic [PRE_W-1:0] c_RELOAD = PRE_W'(PRESCALE - 1);
    localparam logic [PRE_W-1:0] c_ONE    = PRE_W'(1);

    logic [PRE_W-1:0] r_pre;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pre <= '0;
        end else if (reload) begin
            r_pre <= c_RELOAD;
        end else if (enable && (r_pre != '0)) begin
            r_pre <= r_pre - c_ONE;
        end
    end

    assign tick = enable && (r_pre == '0);

endmodule

`default_nettype wire

// File: rtl/delay_timer.sv
// ============================================================================
// Module      : delay_timer
// Description : Programmable delay of (delay_value+1) prescaled ticks with done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module delay_timer
    import delay_timer_pkg::*;
#(
    parameter int CLK_HZ  = c_CLK_HZ_DEFAULT,
    parameter int TICK_HZ = c_TICK_HZ_DEFAULT,
    parameter int DELAY_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start_delay_counter,
    input  logic [DELAY_W-1:0] delay_value,
    output logic               delay_done,
    output logic               delay_busy,
    output logic               tick
);

    localparam int PRESCALE = CLK_HZ / TICK_HZ;
    localparam logic [DELAY_W-1:0] c_COUNT_ONE = DELAY_W'(1);

    if (PRESCALE < 1) begin : g_prescale_check
        $error("delay_timer: CLK_HZ/TICK_HZ must be at least 1");
    end

    logic [1:0]         r_state;
    logic [DELAY_W-1:0] r_count;
    logic               w_tick;
    logic               w_last;
    logic               w_reload;

    assign w_last = (r_count == '0);
    // Reload on arming and on every tick that is not the final one.
    assign w_reload = (r_state == c_DT_LOAD) || (w_tick && !w_last);

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (r_state == c_DT_COUNT),
        .reload  (w_reload),
        .tick    (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_DT_IDLE;
            r_count <= '0;
        end else begin
            case (r_state)
                c_DT_IDLE: begin
                    if (start_delay_counter) begin
                        r_state <= c_DT_LOAD;
                    end
                end
                c_DT_LOAD: begin
                    r_count <= delay_value;
                    r_state <= c_DT_COUNT;
                end
                c_DT_COUNT: begin
                    if (w_tick) begin
                        if (w_last) begin
                            r_state <= c_DT_DONE;
                        end else begin
                            r_count <= r_count - c_COUNT_ONE;
                        end
                    end
                end
                default: begin
                    r_state <= c_DT_IDLE;
                end
            endcase
        end
    end

    assign delay_done = (r_state == c_DT_DONE);
    assign delay_busy = (r_state == c_DT_LOAD) || (r_state == c_DT_COUNT);
    assign tick       = w_tick;

endmodule

`default_nettype wire

// File: tb/tb_delay_timer.sv
// ============================================================================
// Module      : tb_delay_timer
// Description : Directed bench for delay_timer at PRESCALE=10 and PRESCALE=1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_delay_timer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start_a;
    logic [7:0] dv_a;
    logic       done_a, busy_a, tick_a;
    logic       start_b;
    logic [7:0] dv_b;
    logic       done_b, busy_b, tick_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    delay_timer #(.CLK_HZ(10), .TICK_HZ(1), .DELAY_W(8)) u_dut_a (
        .clk                 (clk),
        .reset_n             (reset_n),
        .start_delay_counter (start_a),
        .delay_value         (dv_a),
        .delay_done          (done_a),
        .delay_busy          (busy_a),
        .tick                (tick_a)
    );

    delay_timer #(.CLK_HZ(10), .TICK_HZ(10), .DELAY_W(8)) u_dut_b (
        .clk                 (clk),
        .reset_n             (reset_n),
        .start_delay_counter (start_b),
        .delay_value         (dv_b),
        .delay_done          (done_b),
        .delay_busy          (busy_b),
        .tick                (tick_b)
    );

    // Observed vectors are {busy, done, tick}; cycle n is the one sampled at edge k+n.
    task automatic test_reset();
        logic [5:0] obs;
        reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0; dv_a = '0; dv_b = '0;
        repeat (3) @(negedge clk);
        obs = {busy_a, done_a, tick_a, busy_b, done_b, tick_b};
        total++;
        if (obs !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 000000", obs);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_idle();
        logic [5:0] obs;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            obs = {busy_a, done_a, tick_a, busy_b, done_b, tick_b};
            total++;
            if (obs !== 6'b0) begin
                bad++;
                $display("FAIL idle_cycle%0d: got %b want 000000", n, obs);
            end
        end
    endtask

    task automatic test_basic();
        logic [2:0] obs, exp;
        @(negedge clk);
        dv_a = 8'd2; start_a = 1'b1;
        for (int n = 1; n <= 34; n++) begin
            @(negedge clk);
            if (n == 1) start_a = 1'b0;
            exp = {(n >= 1 && n <= 31), (n == 32), (n == 11 || n == 21 || n == 31)};
            obs = {busy_a, done_a, tick_a};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL basic_k+%0d: got %b want %b", n, obs, exp);
            end
        end
    endtask

    task automatic test_minimum();
        logic [2:0] obs, exp;
        @(negedge clk);
        dv_a = 8'd0; start_a = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == 1) start_a = 1'b0;
            if (n == 3) dv_a = 8'd5;
            exp = {(n <= 11), (n == 12), (n == 11)};
            obs = {busy_a, done_a, tick_a};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL minimum_k+%0d: got %b want %b", n, obs, exp);
            end
        end
        dv_a = 8'd0;
    endtask

    task automatic test_back_to_back();
        logic [2:0] obs, exp;
        int m;
        int pulses;
        pulses = 0;
        @(negedge clk);
        dv_a = 8'd1; start_a = 1'b1;
        for (int n = 1; n <= 92; n++) begin
            @(negedge clk);
            m = ((n - 1) % 23) + 1;
            exp = {(m <= 21), (m == 22), (m == 11 || m == 21)};
            obs = {busy_a, done_a, tick_a};
            if (done_a === 1'b1) pulses++;
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL held_k+%0d: got %b want %b", n, obs, exp);
            end
        end
        start_a = 1'b0;
        total++;
        if (pulses != 4) begin
            bad++;
            $display("FAIL held_pulse_count: got %0d want 4", pulses);
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] obs, exp;
        @(negedge clk);
        dv_a = 8'd2; start_a = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) start_a = 1'b0;
            if (n == 9) reset_n = 1'b1;
            exp = {(n <= 8), 1'b0, 1'b0};
            obs = {busy_a, done_a, tick_a};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL reset_mid_k+%0d: got %b want %b", n, obs, exp);
            end
            if (n == 8) reset_n = 1'b0;
        end
        @(negedge clk);
        dv_a = 8'd0; start_a = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == 1) start_a = 1'b0;
            exp = {(n <= 11), (n == 12), (n == 11)};
            obs = {busy_a, done_a, tick_a};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL after_reset_k+%0d: got %b want %b", n, obs, exp);
            end
        end
    endtask

    task automatic test_prescale_one();
        logic [2:0] obs, exp;
        @(negedge clk);
        dv_b = 8'd255; start_b = 1'b1;
        for (int n = 1; n <= 260; n++) begin
            @(negedge clk);
            if (n == 1) start_b = 1'b0;
            exp = {(n <= 257), (n == 258), (n >= 2 && n <= 257)};
            obs = {busy_b, done_b, tick_b};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL prescale1_k+%0d: got %b want %b", n, obs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_basic();
        test_minimum();
        test_back_to_back();
        test_reset_mid();
        test_prescale_one();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
